// File: rtl/quad_level_counter.sv
// Quadrature encoder front end: sync, glitch filter, Gray-cycle
// tracking and saturating, accelerated level count.
module quad_level_counter #(
  parameter int width     = 8,
  parameter int filt_len  = 4,
  parameter int fast_gap  = 1024,
  parameter int fast_step = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             a,
  input  logic             b,
  input  logic             err_clr,
  output logic [width-1:0] value,
  output logic             dir,
  output logic             step_pulse,
  output logic             err
);

  localparam int fw = $clog2(filt_len + 1);
  localparam int gw = $clog2(fast_gap + 1);
  localparam logic [fw-1:0] f_last = fw'(filt_len - 1);
  localparam logic [gw-1:0] g_max = gw'(fast_gap);
  localparam logic [width:0] v_max = {1'b0, {width{1'b1}}};
  localparam logic [width:0] v_fast = (width + 1)'(fast_step);

  typedef enum logic [1:0] {
    ph_00 = 2'b00,
    ph_01 = 2'b01,
    ph_10 = 2'b10,
    ph_11 = 2'b11
  } phase_t;

  function automatic phase_t cw_next(input phase_t p);
    unique case (p)
      ph_11:   cw_next = ph_10;
      ph_10:   cw_next = ph_00;
      ph_00:   cw_next = ph_01;
      default: cw_next = ph_11;
    endcase
  endfunction

  logic [1:0] sa, sb;
  logic [1:0] s, f;
  logic [fw-1:0] fc [2];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sa <= 2'b11;
      sb <= 2'b11;
    end else begin
      sa <= {sa[0], a};
      sb <= {sb[0], b};
    end
  end

  assign s = {sa[1], sb[1]};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      f     <= 2'b11;
      fc[0] <= '0;
      fc[1] <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (s[i] == f[i]) begin
          fc[i] <= '0;
        end else if (fc[i] == f_last) begin
          f[i]  <= s[i];
          fc[i] <= '0;
        end else begin
          fc[i] <= fc[i] + 1'b1;
        end
      end
    end
  end

  phase_t            ph_q, ph_d;
  logic signed [2:0] pos_q, pos_n;
  logic [gw-1:0]     gap_q, gap_n;
  logic [width-1:0]  val_n;
  logic              dir_n, err_n;
  logic              det_cw, det_ccw, det;
  logic [1:0]        chg;
  logic              one, both, arrive, fwd;
  logic [width:0]    step, sum, diff;

  assign ph_d   = phase_t'(f);
  assign chg    = ph_d ^ ph_q;
  assign one    = ^chg;
  assign both   = &chg;
  assign arrive = one & (ph_d == ph_11);
  assign fwd    = (ph_d == cw_next(ph_q));

  always_comb begin
    pos_n   = pos_q;
    det_cw  = 1'b0;
    det_ccw = 1'b0;
    err_n   = err_clr ? 1'b0 : err;
    unique case (1'b1)
      both: begin
        err_n = 1'b1;
        pos_n = '0;
      end
      arrive: begin
        det_cw  = (pos_q == 3'sd3);
        det_ccw = (pos_q == -3'sd3);
        pos_n   = '0;
      end
      (one & !arrive & fwd):  pos_n = pos_q + 3'sd1;
      (one & !arrive & !fwd): pos_n = pos_q - 3'sd1;
      default: ;
    endcase
  end

  // A detent is fast only if the previous one was under fast_gap ago
  always_comb begin
    det   = det_cw | det_ccw;
    step  = (gap_q < g_max) ? v_fast : {{width{1'b0}}, 1'b1};
    sum   = {1'b0, value} + step;
    diff  = {1'b0, value} - step;
    val_n = value;
    dir_n = dir;
    gap_n = (gap_q == g_max) ? gap_q : gap_q + 1'b1;
    if (det_cw) begin
      val_n = (sum > v_max) ? v_max[width-1:0] : sum[width-1:0];
      dir_n = 1'b1;
    end
    if (det_ccw) begin
      val_n = diff[width] ? '0 : diff[width-1:0];
      dir_n = 1'b0;
    end
    if (det) gap_n = '0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ph_q       <= ph_11;
      pos_q      <= '0;
      gap_q      <= g_max;
      value      <= '0;
      dir        <= 1'b0;
      step_pulse <= 1'b0;
      err        <= 1'b0;
    end else begin
      ph_q       <= ph_d;
      pos_q      <= pos_n;
      gap_q      <= gap_n;
      value      <= val_n;
      dir        <= dir_n;
      step_pulse <= det;
      err        <= err_n;
    end
  end

endmodule

// File: tb/tb_quad_level_counter.sv
// Bench for quad_level_counter: stimulus-side model pushes
// expected detents, a monitor pops them on step_pulse.
module tb_quad_level_counter;

  localparam int W  = 8;
  localparam int FL = 4;
  localparam int FG = 64;
  localparam int FS = 4;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         a = 1'b1;
  logic         b = 1'b1;
  logic         err_clr = 1'b0;
  logic [W-1:0] value;
  logic         dir;
  logic         step_pulse;
  logic         err;

  quad_level_counter #(
    .width(W),
    .filt_len(FL),
    .fast_gap(FG),
    .fast_step(FS)
  ) dut (
    .clk(clk),
    .reset(reset),
    .a(a),
    .b(b),
    .err_clr(err_clr),
    .value(value),
    .dir(dir),
    .step_pulse(step_pulse),
    .err(err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int mv = 0;
  int md = 0;
  int last = -1;
  logic [8:0] q[$];
  logic prev_sp = 1'b0;

  always @(posedge clk) cyc++;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    logic [8:0] e;
    if (reset && step_pulse) begin
      chk("step_expected", int'(q.size() > 0), 1);
      chk("step_gap", int'(prev_sp), 0);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("value", int'(value), int'(e[7:0]));
        chk("dir", int'(dir), int'(e[8]));
      end
    end
    prev_sp = reset & step_pulse;
  end

  task automatic hold(input logic na, input logic nb, input int n);
    a = na;
    b = nb;
    repeat (n) @(negedge clk);
  endtask

  task automatic expect_det(input logic cw);
    int k;
    int st;
    logic [31:0] v;
    k  = cyc - last;
    st = (last >= 0 && k < FG) ? FS : 1;
    if (cw) mv = (mv + st > 255) ? 255 : mv + st;
    else    mv = (mv - st < 0) ? 0 : mv - st;
    md = cw ? 1 : 0;
    v  = mv;
    q.push_back({cw, v[7:0]});
    last = cyc;
  endtask

  task automatic turn(input logic cw, input int h);
    if (cw) begin
      hold(1, 0, h);
      hold(0, 0, h);
      hold(0, 1, h);
    end else begin
      hold(0, 1, h);
      hold(0, 0, h);
      hold(1, 0, h);
    end
    expect_det(cw);
    hold(1, 1, h);
  endtask

  task automatic drain();
    for (int i = 0; i < 60 && q.size() != 0; i++) @(negedge clk);
    chk("drain", q.size(), 0);
    chk("value_model", int'(value), mv);
  endtask

  initial begin
    #2 reset = 1'b0;
    repeat (5) @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      chk("rst_value", int'(value), 0);
      chk("rst_dir", int'(dir), 0);
      chk("rst_err", int'(err), 0);
      chk("rst_step", int'(step_pulse), 0);
    end

    turn(1, 10);
    turn(1, 10);
    repeat (160) @(negedge clk);
    turn(1, 10);
    drain();
    chk("accel", int'(value), 6);

    for (int i = 0; i < 300; i++) begin
      turn(1, 10);
      repeat (40) @(negedge clk);
    end
    turn(1, 5);
    drain();
    chk("sat_hi", int'(value), 255);

    for (int i = 0; i < 70; i++) turn(0, 5);
    repeat (80) @(negedge clk);
    turn(0, 10);
    drain();
    chk("sat_lo", int'(value), 0);
    chk("ccw_dir", int'(dir), 0);

    a = 1'b0;
    repeat (3) @(negedge clk);
    a = 1'b1;
    repeat (30) @(negedge clk);
    drain();
    chk("glitch_err", int'(err), 0);

    hold(1, 0, 10);
    hold(0, 0, 10);
    hold(1, 0, 10);
    hold(1, 1, 10);
    repeat (20) @(negedge clk);
    drain();
    chk("partial_err", int'(err), 0);

    a = 1'b0;
    b = 1'b0;
    repeat (6) @(negedge clk);
    chk("err_early", int'(err), 0);
    @(negedge clk);
    chk("err_set", int'(err), 1);
    repeat (50) @(negedge clk);
    chk("err_sticky", int'(err), 1);
    chk("illegal_value", int'(value), mv);
    hold(1, 1, 20);
    chk("err_sticky2", int'(err), 1);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    chk("err_clr", int'(err), 0);

    a = 1'b0;
    b = 1'b0;
    repeat (6) @(negedge clk);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    chk("err_set_wins", int'(err), 1);
    hold(1, 1, 20);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    chk("err_clr2", int'(err), 0);
    drain();

    repeat (80) @(negedge clk);
    turn(1, 10);
    turn(1, 10);
    drain();
    hold(1, 0, 10);
    hold(0, 0, 10);
    hold(0, 1, 10);
    reset = 1'b0;
    a = 1'b1;
    b = 1'b1;
    #1;
    chk("async_reset", int'(value), 0);
    mv = 0;
    last = -1;
    repeat (5) @(negedge clk);
    reset = 1'b1;
    repeat (50) @(negedge clk);
    chk("post_rst_value", int'(value), 0);
    turn(1, 10);
    drain();
    chk("post_rst_first", int'(value), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
